regfile_32x64: RTL and testbench

//   32-entry register file for the pipelined CPU; the block directly downstream of
//   the write-enable decode tree.
//   - Write path: a 5:32 decoder, built from the 2:4 decoder cell gated by RegWrite,

---
 rtl/regfile_32x64.sv | 94 +++++++++
 tb/tb_regfile_32x64.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_32x64.sv
// ---------------------------------------------------------------------------
// regfile_32x64
//   32-entry register file for the pipelined CPU. Registers 0..30 are
//   WIDTH-bit flops; register 31 (XZR) is not stored and always reads zero.
//   Write enables come from a 2:4 bank decoder gated by RegWrite, followed by
//   a 3:8 decode inside each bank. Two independent combinational read ports
//   feed the ID stage, with an optional write-through bypass (BYPASS=1) that
//   returns WriteData for the register being written this cycle.
//
// Ports
//   clk            in   1      rising-edge clock
//   reset          in   1      synchronous reset, active-high (clears 0..30)
//   RegWrite       in   1      write enable from WB
//   WriteRegister  in   5      destination register index
//   WriteData      in   WIDTH  data to write
//   ReadRegister1  in   5      read port 1 index
//   ReadRegister2  in   5      read port 2 index
//   ReadData1      out  WIDTH  read port 1 data
//   ReadData2      out  WIDTH  read port 2 data
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module regfile_32x64 #(
    parameter int unsigned WIDTH  = 64,
    parameter bit          BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);

    logic [3:0]       w_bank_en;
    logic [31:0]      w_we;
    logic [WIDTH-1:0] r_regs   [0:30];
    logic [WIDTH-1:0] w_stored [0:31];

    // Bank enables are ANDed with RegWrite first, so an unknown
    // WriteRegister while RegWrite=0 still yields all-zero enables.
    always_comb begin
        w_bank_en = '0;
        w_we      = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            w_bank_en[b] = RegWrite && (WriteRegister[4:3] == b[1:0]);
        end
        for (int unsigned b = 0; b < 4; b++) begin
            for (int unsigned r = 0; r < 8; r++) begin
                w_we[b*8 + r] = w_bank_en[b] && (WriteRegister[2:0] == r[2:0]);
            end
        end
        // XZR: writes to 31 are dropped.
        w_we[31] = 1'b0;
    end

    // Reset has priority over any write presented at the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 31; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 31; i++) begin
                if (w_we[i]) begin
                    r_regs[i] <= WriteData;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 31; i++) begin
            w_stored[i] = r_regs[i];
        end
        w_stored[31] = '0;
    end

    // w_we[idx] already means "RegWrite, idx matches, idx != 31", which is
    // exactly the bypass condition for that read index.
    always_comb begin
        ReadData1 = w_stored[ReadRegister1];
        ReadData2 = w_stored[ReadRegister2];
        if (BYPASS && w_we[ReadRegister1]) begin
            ReadData1 = WriteData;
        end
        if (BYPASS && w_we[ReadRegister2]) begin
            ReadData2 = WriteData;
        end
    end

endmodule

// File: tb/tb_regfile_32x64.sv
// ---------------------------------------------------------------------------
// tb_regfile_32x64
//   Drives one bypassing and one non-bypassing register file with the same
//   directed vectors. A behavioural model (plain array plus read rules) is
//   checked against all four read ports every cycle; literal expectations
//   at key points pin the model itself.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_32x64;

    localparam logic [63:0] PAT = 64'hA5A5_0000_0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] rd1_b, rd2_b, rd1_n, rd2_n;

    int vectors    = 0;
    int miscompares = 0;
    bit chk_en     = 1'b0;

    logic [63:0] m [0:31];

    always #5 clk = ~clk;

    regfile_32x64 #(.WIDTH(64), .BYPASS(1'b1)) dut_b (
        .clk(clk), .reset(reset), .RegWrite(RegWrite),
        .WriteRegister(WriteRegister), .WriteData(WriteData),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(rd1_b), .ReadData2(rd2_b)
    );

    regfile_32x64 #(.WIDTH(64), .BYPASS(1'b0)) dut_n (
        .clk(clk), .reset(reset), .RegWrite(RegWrite),
        .WriteRegister(WriteRegister), .WriteData(WriteData),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(rd1_n), .ReadData2(rd2_n)
    );

    // Model state: what each architectural register holds.
    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 31; k++) m[k] <= '0;
        end else if (RegWrite === 1'b1 && WriteRegister != 5'd31) begin
            m[WriteRegister] <= WriteData;
        end
    end

    function automatic logic [63:0] exp_rd(input logic [4:0] idx, input bit byp);
        if (idx == 5'd31) return '0;
        if (byp && RegWrite === 1'b1 && idx == WriteRegister) return WriteData;
        return m[idx];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Sampled 1 ns before each rising edge, well after inputs settle.
    always @(negedge clk) begin
        #4;
        if (chk_en) begin
            check("model_p1_byp",   rd1_b, exp_rd(ReadRegister1, 1'b1));
            check("model_p2_byp",   rd2_b, exp_rd(ReadRegister2, 1'b1));
            check("model_p1_nobyp", rd1_n, exp_rd(ReadRegister1, 1'b0));
            check("model_p2_nobyp", rd2_n, exp_rd(ReadRegister2, 1'b0));
        end
    end

    // Inputs change 1 ns after an edge; literal checks land mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rw, input logic [4:0] wr, input logic [63:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
        RegWrite      = rw;
        WriteRegister = wr;
        WriteData     = wd;
        ReadRegister1 = r1;
        ReadRegister2 = r2;
        #4;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got timeout expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
        ReadRegister1 = '0; ReadRegister2 = '0;
        step();
        reset = 1'b0;
        chk_en = 1'b1;

        // 1: everything reads zero after reset.
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, '0, 5'(i), 5'(31 - i));
            check("rst_p1", rd1_b, 64'h0);
            check("rst_p2", rd2_n, 64'h0);
            step();
        end

        // 2: write every register; bypass shows new data pre-edge, the other old.
        for (int i = 0; i < 31; i++) begin
            drive(1'b1, 5'(i), PAT | 64'(i), 5'(i), 5'd31);
            check("wr_byp_pre",   rd1_b, PAT | 64'(i));
            check("wr_nobyp_pre", rd1_n, 64'h0);
            step();
        end
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, '0, 5'(i), 5'(i));
            check("rb_p1", rd1_n, (i == 31) ? 64'h0 : (PAT | 64'(i)));
            check("rb_p2", rd2_b, (i == 31) ? 64'h0 : (PAT | 64'(i)));
            step();
        end

        // 3: write to XZR is dropped and never bypassed.
        drive(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd30);
        check("xzr_byp_pre", rd1_b, 64'h0);
        step();
        drive(1'b0, 5'd31, '0, 5'd31, 5'd30);
        check("xzr_after", rd1_n, 64'h0);
        check("r30_kept",  rd2_n, PAT | 64'd30);
        step();
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, '0, 5'(i), 5'(31 - i));
            step();
        end

        // 4: RegWrite=0 holds reg5; RegWrite=1 then writes it.
        drive(1'b0, 5'd5, 64'h1234, 5'd5, 5'd0);
        step();
        drive(1'b0, 5'd5, 64'h1234, 5'd5, 5'd0);
        check("rw0_hold", rd1_b, PAT | 64'd5);
        drive(1'b1, 5'd5, 64'h1234, 5'd5, 5'd0);
        step();
        drive(1'b0, 5'd0, '0, 5'd5, 5'd5);
        check("rw1_write", rd1_n, 64'h1234);

        // 5: bypass vs. stored value for a back-to-back rewrite of reg7.
        drive(1'b1, 5'd7, 64'h1, 5'd7, 5'd7);
        step();
        drive(1'b1, 5'd7, 64'h2, 5'd7, 5'd7);
        check("bp_byp_pre",   rd1_b, 64'h2);
        check("bp_nobyp_pre", rd1_n, 64'h1);
        check("bp_byp_p2",    rd2_b, 64'h2);
        step();
        drive(1'b0, 5'd0, '0, 5'd7, 5'd7);
        check("bp_nobyp_post", rd1_n, 64'h2);
        check("bp_byp_post",   rd2_b, 64'h2);

        // Unknown write index with RegWrite=0 must not touch anything.
        drive(1'b0, 5'bxxxxx, 64'hCAFE, 5'd5, 5'd0);
        step();
        drive(1'b0, 5'd0, '0, 5'd5, 5'd0);
        check("x_idx_r5", rd1_n, 64'h1234);
        check("x_idx_r0", rd2_n, PAT);
        step();

        // 6: reset beats a write at the same edge.
        drive(1'b1, 5'd10, 64'hDEAD, 5'd10, 5'd30);
        step();
        reset = 1'b1;
        drive(1'b1, 5'd10, 64'hBEEF, 5'd10, 5'd30);
        check("rst_pre_old", rd1_n, 64'hDEAD);
        step();
        reset = 1'b0;
        drive(1'b0, 5'd0, '0, 5'd10, 5'd30);
        check("rst_r10_p1", rd1_b, 64'h0);
        check("rst_r30_p2", rd2_n, 64'h0);
        step();
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, '0, 5'(i), 5'(i));
            step();
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
